// File: rtl/gpio_cond_pkg.sv
// Shared constants and width helpers for the GPIO input conditioner.
// Used by gpio_in_cond and gpio_debounce_bit.
package gpio_cond_pkg;

    localparam int unsigned GPIO_COND_PRESCALE = 1000;
    localparam int unsigned GPIO_COND_STABLE   = 4;

    // clog2 clamped to at least one bit so degenerate counters still exist
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

    function automatic int unsigned presc_width(input int unsigned prescale);
        return clog2_min1(prescale);
    endfunction

    function automatic int unsigned cnt_width(input int unsigned stable);
        return clog2_min1(stable);
    endfunction

endpackage

// File: rtl/gpio_debounce_bit.sv
// One bit of the input conditioner: two-flop synchroniser,
// tick-paced debounce counter and registered rise/fall strobes.
module gpio_debounce_bit
    import gpio_cond_pkg::*;
#(
    parameter int unsigned STABLE    = GPIO_COND_STABLE,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic tick_i,
    input  logic pad_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned CW = cnt_width(STABLE);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;

    // Debounce decision: only a tick can move the counter or the level
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (tick_i) begin
            if (sync2_q == level_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
                cnt_d   = '0;
                rise_d  = ~level_q;
                fall_d  = level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchroniser, level, counter and strobe registers
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= RESET_VAL;
            sync2_q <= RESET_VAL;
            level_q <= RESET_VAL;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= pad_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/gpio_in_cond.sv
// GPIO input conditioner: shared debounce prescaler plus WIDTH bit slices.
// Optional sticky event flags and irq_o under `GPIO_COND_EVENT_EN.
module gpio_in_cond
    import gpio_cond_pkg::*;
#(
    parameter int unsigned      WIDTH     = 32,
    parameter int unsigned      PRESCALE  = GPIO_COND_PRESCALE,
    parameter int unsigned      STABLE    = GPIO_COND_STABLE,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pad_i,
    output logic [WIDTH-1:0] gpio_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
`ifdef GPIO_COND_EVENT_EN
    ,
    input  logic [WIDTH-1:0] rise_en_i,
    input  logic [WIDTH-1:0] fall_en_i,
    input  logic [WIDTH-1:0] evt_clr_i,
    output logic [WIDTH-1:0] evt_o,
    output logic             irq_o
`endif
);

    localparam int unsigned PW = presc_width(PRESCALE);
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic          tick;

    assign tick = (presc_q == PRESC_LAST);

    // Free-running sample prescaler, wraps after PRESCALE cycles
    always_comb begin
        presc_d = tick ? '0 : presc_q + 1'b1;
    end

    // Prescaler register
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        gpio_debounce_bit #(
            .STABLE    (STABLE),
            .RESET_VAL (RESET_VAL[i])
        ) u_bit (
            .clk     (clk),
            .reset   (reset),
            .tick_i  (tick),
            .pad_i   (pad_i[i]),
            .level_o (gpio_o[i]),
            .rise_o  (rise_o[i]),
            .fall_o  (fall_o[i])
        );
    end

`ifdef GPIO_COND_EVENT_EN
    logic [WIDTH-1:0] evt_q, evt_d;

    // Sticky flags: a new enabled edge beats a simultaneous clear
    always_comb begin
        evt_d = (evt_q & ~evt_clr_i)
              | (rise_o & rise_en_i)
              | (fall_o & fall_en_i);
    end

    // Event flag register
    always_ff @(posedge clk) begin
        if (reset) begin
            evt_q <= '0;
        end else begin
            evt_q <= evt_d;
        end
    end

    assign evt_o = evt_q;
    assign irq_o = |evt_q;
`endif

endmodule
